// File: rtl/pipe_pkg.sv
// Shared widths, opcode constants and issue-state encoding for the IF/ID1 issue pipe.
// Used by if_id1_issue_pipe and pair_dep_check.
package pipe_pkg;
  localparam int PC_W   = 8;
  localparam int INST_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  typedef enum logic {
    ST_PAIR  = 1'b0,
    ST_SPLIT = 1'b1
  } issue_state_t;

  // Register written by an instruction; 0 means no destination ($0 is never a real target).
  function automatic logic [4:0] dest_reg(input logic [INST_W-1:0] inst);
    logic [4:0] dst;
    dst = 5'd0;
    case (inst[31:26])
      OP_RTYPE: dst = inst[15:11];
      OP_LW, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: dst = inst[20:16];
      default: dst = 5'd0;
    endcase
    return dst;
  endfunction
endpackage

// File: rtl/pair_dep_check.sv
// Combinational RAW check between the two instructions of a fetched pair.
// dep is high when inst2 reads (rs or rt) the non-zero register inst1 writes.
module pair_dep_check
  import pipe_pkg::*;
(
  input  logic [INST_W-1:0] inst1,
  input  logic [INST_W-1:0] inst2,
  output logic              dep
);
  logic [4:0] dst;

  assign dst = dest_reg(inst1);
  assign dep = (dst != 5'd0) && ((dst == inst2[25:21]) || (dst == inst2[20:16]));
endmodule

// File: rtl/if_id1_issue_pipe.sv
// IF -> ID1 pipeline register for a dual-issue front end.
// Define SPLIT_ISSUE_EN to split dependent pairs over two cycles; otherwise every pair issues together.
module if_id1_issue_pipe
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [INST_W-1:0] inst1_F,
  input  logic [INST_W-1:0] inst2_F,
  input  logic [PC_W-1:0]   pc_F,
  input  logic              flush,
  input  logic              stall,
  output logic [INST_W-1:0] inst1_D,
  output logic [INST_W-1:0] inst2_D,
  output logic [PC_W-1:0]   pc1_D,
  output logic [PC_W-1:0]   pcPlus2_D,
  output logic              valid1_D,
  output logic              valid2_D,
  output logic              fetch_hold,
  output logic              split_active
);
  // Handshake: there is no valid/ready pair here; stall freezes ID1 and
  // fetch_hold asks the PC register to repeat the current fetch for one cycle.

`ifdef SPLIT_ISSUE_EN
  issue_state_t             state;
  logic [INST_W-1:0]        buf_inst;
  logic [PC_W-1:0]          buf_pc;
  logic                     dep;

  pair_dep_check u_dep_check (
    .inst1 (inst1_F),
    .inst2 (inst2_F),
    .dep   (dep)
  );

  // Gated by reset so the PC is never held while the pipe is being reset.
  assign fetch_hold   = reset & (state == ST_PAIR) & dep & ~stall & ~flush;
  assign split_active = (state == ST_SPLIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_PAIR;
      buf_inst  <= '0;
      buf_pc    <= '0;
      inst1_D   <= '0;
      inst2_D   <= '0;
      pc1_D     <= '0;
      pcPlus2_D <= '0;
      valid1_D  <= 1'b0;
      valid2_D  <= 1'b0;
    end else if (flush) begin
      state     <= ST_PAIR;
      buf_inst  <= '0;
      buf_pc    <= '0;
      inst1_D   <= '0;
      inst2_D   <= '0;
      pc1_D     <= '0;
      pcPlus2_D <= '0;
      valid1_D  <= 1'b0;
      valid2_D  <= 1'b0;
    end else if (!stall) begin
      case (state)
        ST_SPLIT: begin
          // The fetched pair is a repeat of the held fetch; drain the buffer instead.
          state     <= ST_PAIR;
          inst1_D   <= buf_inst;
          inst2_D   <= '0;
          pc1_D     <= buf_pc;
          pcPlus2_D <= buf_pc + PC_W'(1);
          valid1_D  <= 1'b1;
          valid2_D  <= 1'b0;
          buf_inst  <= '0;
          buf_pc    <= '0;
        end
        default: begin
          inst1_D   <= inst1_F;
          pc1_D     <= pc_F;
          pcPlus2_D <= pc_F + PC_W'(2);
          valid1_D  <= 1'b1;
          if (dep) begin
            state    <= ST_SPLIT;
            inst2_D  <= '0;
            valid2_D <= 1'b0;
            buf_inst <= inst2_F;
            buf_pc   <= pc_F + PC_W'(1);
          end else begin
            state    <= ST_PAIR;
            inst2_D  <= inst2_F;
            valid2_D <= 1'b1;
          end
        end
      endcase
    end
  end
`else
  assign fetch_hold   = 1'b0;
  assign split_active = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inst1_D   <= '0;
      inst2_D   <= '0;
      pc1_D     <= '0;
      pcPlus2_D <= '0;
      valid1_D  <= 1'b0;
      valid2_D  <= 1'b0;
    end else if (flush) begin
      inst1_D   <= '0;
      inst2_D   <= '0;
      pc1_D     <= '0;
      pcPlus2_D <= '0;
      valid1_D  <= 1'b0;
      valid2_D  <= 1'b0;
    end else if (!stall) begin
      inst1_D   <= inst1_F;
      inst2_D   <= inst2_F;
      pc1_D     <= pc_F;
      pcPlus2_D <= pc_F + PC_W'(2);
      valid1_D  <= 1'b1;
      valid2_D  <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_if_id1_issue_pipe.sv
// Self-checking bench for if_id1_issue_pipe; follows SPLIT_ISSUE_EN the same way the design does.
// Reference model keeps pending lower instructions in a queue and derives ID1 contents from it.
module tb_if_id1_issue_pipe;
  localparam int OW = 83;

`ifdef SPLIT_ISSUE_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] inst1_F, inst2_F;
  logic [7:0]  pc_F;
  logic        flush, stall;
  logic [31:0] inst1_D, inst2_D;
  logic [7:0]  pc1_D, pcPlus2_D;
  logic        valid1_D, valid2_D, fetch_hold, split_active;

  if_id1_issue_pipe dut (
    .clk          (clk),
    .reset        (reset),
    .inst1_F      (inst1_F),
    .inst2_F      (inst2_F),
    .pc_F         (pc_F),
    .flush        (flush),
    .stall        (stall),
    .inst1_D      (inst1_D),
    .inst2_D      (inst2_D),
    .pc1_D        (pc1_D),
    .pcPlus2_D    (pcPlus2_D),
    .valid1_D     (valid1_D),
    .valid2_D     (valid2_D),
    .fetch_hold   (fetch_hold),
    .split_active (split_active)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [OW-1:0] exp_q[$];
  logic [39:0]   pend_q[$];      // {lower instruction, its pc} waiting to issue
  logic [OW-1:0] m_out;          // model ID1 contents without split flag
  logic          fh_exp, fh_obs;
  logic [OW-1:0] e, o;
  int            n_cmp, n_fail;

  localparam logic [31:0] ADD_3_1_2 = 32'h00221820; // add $3,$1,$2
  localparam logic [31:0] ADD_6_4_5 = 32'h00853020; // add $6,$4,$5
  localparam logic [31:0] ADD_7_3_4 = 32'h00643820; // add $7,$3,$4
  localparam logic [31:0] ADD_0_1_2 = 32'h00220020; // add $0,$1,$2
  localparam logic [31:0] ADD_7_0_4 = 32'h00043820; // add $7,$0,$4

  function automatic logic [OW-1:0] obs_vec();
    return {inst1_D, inst2_D, pc1_D, pcPlus2_D, valid1_D, valid2_D, split_active};
  endfunction

  function automatic logic [4:0] m_dest(input logic [31:0] i);
    int op;
    op = int'(i[31:26]);
    if (op == 0) return i[15:11];
    if (op == 'h23 || op == 'h08 || op == 'h0A || op == 'h0C || op == 'h0D || op == 'h0E)
      return i[20:16];
    return 5'd0;
  endfunction

  task automatic model_reset();
    pend_q.delete();
    m_out = '0;
  endtask

  // Apply one clock edge of the specification's rules to the model.
  task automatic model_edge(input logic [31:0] i1, input logic [31:0] i2, input logic [7:0] pc,
                            input logic fl, input logic st);
    logic [4:0]  d;
    logic        dep;
    logic [39:0] p;
    logic [7:0]  q;
    d   = m_dest(i1);
    dep = SPLIT_EN && (d != 0) && (d == i2[25:21] || d == i2[20:16]);
    fh_exp = (pend_q.size() == 0) && dep && !st && !fl;
    if (fl) begin
      model_reset();
    end else if (!st) begin
      if (pend_q.size() != 0) begin
        p = pend_q.pop_front();
        q = p[7:0] + 8'd1;
        m_out = {p[39:8], 32'd0, p[7:0], q, 1'b1, 1'b0, 1'b0};
      end else if (dep) begin
        q = pc + 8'd1;
        pend_q.push_back({i2, q});
        q = pc + 8'd2;
        m_out = {i1, 32'd0, pc, q, 1'b1, 1'b0, 1'b0};
      end else begin
        q = pc + 8'd2;
        m_out = {i1, i2, pc, q, 1'b1, 1'b1, 1'b0};
      end
    end
    exp_q.push_back({m_out[OW-1:1], pend_q.size() != 0});
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [31:0] i1, input logic [31:0] i2, input logic [7:0] pc,
                      input logic fl, input logic st);
    @(negedge clk);
    inst1_F = i1; inst2_F = i2; pc_F = pc; flush = fl; stall = st;
    #1;
    fh_obs = fetch_hold;
    model_edge(i1, i2, pc, fl, st);
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; inst1_F = ADD_3_1_2; inst2_F = ADD_7_3_4; pc_F = 8'h40; flush = 0; stall = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (obs_vec() !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h required 0", obs_vec());
    end
    n_cmp++;
    if (fetch_hold !== 1'b0) begin
      n_fail++; $display("FAIL reset_fetch_hold: got %b required 0", fetch_hold);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_independent();
    step(ADD_3_1_2, ADD_6_4_5, 8'h10, 0, 0);
    e = exp_q.pop_front(); o = obs_vec();
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL indep_out: got %h required %h", o, e); end
    n_cmp++;
    if (fh_obs !== 1'b0) begin n_fail++; $display("FAIL indep_hold: got %b required 0", fh_obs); end
    n_cmp++;
    if ({pc1_D, pcPlus2_D, valid1_D, valid2_D} !== {8'h10, 8'h12, 2'b11}) begin
      n_fail++; $display("FAIL indep_pc: got %h/%h v%b%b required 10/12 v11", pc1_D, pcPlus2_D, valid1_D, valid2_D);
    end
  endtask

  task automatic test_dependent();
    logic [31:0] i1s[3] = '{ADD_3_1_2, ADD_6_4_5, ADD_3_1_2};
    logic [31:0] i2s[3] = '{ADD_7_3_4, ADD_3_1_2, ADD_6_4_5};
    logic [7:0]  pcs[3] = '{8'h20, 8'h22, 8'h22};
    for (int k = 0; k < 3; k++) begin
      step(i1s[k], i2s[k], pcs[k], 0, 0);
      e = exp_q.pop_front(); o = obs_vec();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL dep_out[%0d]: got %h required %h", k, o, e); end
      n_cmp++;
      if (fh_obs !== fh_exp) begin n_fail++; $display("FAIL dep_hold[%0d]: got %b required %b", k, fh_obs, fh_exp); end
    end
  endtask

  task automatic test_stall_split();
    logic st;
    for (int k = 0; k < 6; k++) begin
      st = (k >= 1 && k <= 3);
      step(ADD_3_1_2, ADD_7_3_4, 8'h30, 0, st);
      e = exp_q.pop_front(); o = obs_vec();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL stall_out[%0d]: got %h required %h", k, o, e); end
      n_cmp++;
      if (fh_obs !== fh_exp) begin n_fail++; $display("FAIL stall_hold[%0d]: got %b required %b", k, fh_obs, fh_exp); end
    end
  endtask

  task automatic test_flush_stall();
    step(ADD_3_1_2, ADD_7_3_4, 8'h50, 0, 0);
    void'(exp_q.pop_front());
    step(ADD_3_1_2, ADD_7_3_4, 8'h50, 1, 1);
    e = exp_q.pop_front(); o = obs_vec();
    n_cmp++;
    if (o !== '0 || o !== e) begin n_fail++; $display("FAIL flush_out: got %h required 0", o); end
    n_cmp++;
    if (fh_obs !== 1'b0) begin n_fail++; $display("FAIL flush_hold: got %b required 0", fh_obs); end
    step(ADD_3_1_2, ADD_6_4_5, 8'h52, 0, 0);
    e = exp_q.pop_front(); o = obs_vec();
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL flush_after: got %h required %h", o, e); end
  endtask

  task automatic test_wrap();
    logic [31:0] i1s[4] = '{ADD_3_1_2, ADD_3_1_2, ADD_0_1_2, ADD_0_1_2};
    logic [31:0] i2s[4] = '{ADD_7_3_4, ADD_7_3_4, ADD_7_0_4, ADD_7_0_4};
    logic [7:0]  pcs[4] = '{8'hFF, 8'hFF, 8'hFE, 8'hFF};
    for (int k = 0; k < 4; k++) begin
      step(i1s[k], i2s[k], pcs[k], 0, 0);
      e = exp_q.pop_front(); o = obs_vec();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL wrap_out[%0d]: got %h required %h", k, o, e); end
      n_cmp++;
      if (fh_obs !== fh_exp) begin n_fail++; $display("FAIL wrap_hold[%0d]: got %b required %b", k, fh_obs, fh_exp); end
    end
    n_cmp++;
    if ({pc1_D, pcPlus2_D} !== {8'hFF, 8'h01}) begin
      n_fail++; $display("FAIL wrap_pc: got %h/%h required ff/01", pc1_D, pcPlus2_D);
    end
  endtask

  task automatic test_reset_mid_split();
    step(ADD_3_1_2, ADD_7_3_4, 8'h60, 0, 0);
    void'(exp_q.pop_front());
    reset = 1'b0;
    #1;
    n_cmp++;
    if (obs_vec() !== '0) begin n_fail++; $display("FAIL rst_mid_out: got %h required 0", obs_vec()); end
    n_cmp++;
    if (fetch_hold !== 1'b0) begin n_fail++; $display("FAIL rst_mid_hold: got %b required 0", fetch_hold); end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(ADD_3_1_2, ADD_6_4_5, 8'h70, 0, 0);
    e = exp_q.pop_front(); o = obs_vec();
    n_cmp++;
    if (o !== e) begin n_fail++; $display("FAIL rst_after: got %h required %h", o, e); end
  endtask

  function automatic logic [31:0] rand_inst();
    logic [5:0] ops[7] = '{6'h00, 6'h00, 6'h23, 6'h08, 6'h0D, 6'h02, 6'h04};
    logic [5:0] op;
    op = ops[$urandom_range(0, 6)];
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 11'($urandom_range(0, 2047))};
  endfunction

  task automatic test_random();
    logic fl, st;
    for (int k = 0; k < 400; k++) begin
      fl = ($urandom_range(0, 9) == 0);
      st = ($urandom_range(0, 4) == 0);
      step(rand_inst(), rand_inst(), 8'($urandom_range(0, 255)), fl, st);
      e = exp_q.pop_front(); o = obs_vec();
      n_cmp++;
      if (o !== e) begin n_fail++; $display("FAIL rand_out[%0d]: got %h required %h", k, o, e); end
      n_cmp++;
      if (fh_obs !== fh_exp) begin n_fail++; $display("FAIL rand_hold[%0d]: got %b required %b", k, fh_obs, fh_exp); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0; n_fail = 0;
    test_reset();
    test_independent();
    test_dependent();
    test_stall_split();
    test_flush_stall();
    test_wrap();
    test_reset_mid_split();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/if_id1_issue_pipe.md
IF_ID1_ISSUE_PIPE -- requirements
Module: if_id1_issue_pipe

Interface
REQ-001 clk  input  1  rising-edge clock.
REQ-002 reset  input  1  asynchronous, active-low reset; clock clk.
REQ-003 inst1_F  input  32  upper fetched instruction, word at pc_F.
REQ-004 inst2_F  input  32  lower fetched instruction, word at pc_F+1.
REQ-005 pc_F  input  8  word address of inst1_F.
REQ-006 flush  input  1  kill ID1 contents (jump resolved in decode or branch mispredict in EX).
REQ-007 stall  input  1  hazard-unit hold of ID1 contents.
REQ-008 inst1_D, inst2_D  output  32 each  ID1 upper/lower instruction.
REQ-009 pc1_D  output  8  address of ID1 upper instruction.
REQ-010 pcPlus2_D  output  8  address of the next fetch pair.
REQ-011 valid1_D, valid2_D  output  1 each  slot valid.
REQ-012 fetch_hold  output  1  combinational; PC register shall not advance this cycle.
REQ-013 split_active  output  1  registered; high while in state SPLIT.

Function
REQ-014 Priority per edge: reset > flush > stall > state action.
REQ-015 States: PAIR (normal dual issue), SPLIT (buffered lower instruction pending).
REQ-016 Dependency dep: inst1_F destination non-zero and equal to inst2_F rs [25:21] or rt [20:16].
REQ-017 inst1_F destination: opcode 0 -> rd [15:11]; opcode 0x23, 0x08, 0x0A, 0x0C, 0x0D, 0x0E -> rt [20:16]; any other opcode -> no destination.
REQ-018 PAIR, no dep: latch inst1_F, inst2_F; pc1_D=pc_F; pcPlus2_D=pc_F+2; valid1_D=valid2_D=1; stay PAIR.
REQ-019 PAIR, dep: latch inst1_F only; inst2_D=0, valid2_D=0; valid1_D=1; pc1_D=pc_F; pcPlus2_D=pc_F+2; buffer inst2_F and pc_F+1; go SPLIT.
REQ-020 fetch_hold = state PAIR & dep & ~stall & ~flush; zero otherwise.
REQ-021 SPLIT, no stall/flush: inst1_D=buffer; pc1_D=buffered pc; pcPlus2_D=buffered pc+1; valid1_D=1; inst2_D=0; valid2_D=0; fetched pair ignored; go PAIR.
REQ-022 stall: all outputs, state and buffer hold; a pending SPLIT is preserved across any stall length.
REQ-023 flush: all outputs zero, valids 0, buffer cleared, state PAIR; flush overrides simultaneous stall.
REQ-024 All PC arithmetic is modulo 256; pc_F=0xFF gives pcPlus2_D=0x01, split pc1_D=0x00.
REQ-025 Latency: one cycle fetch-to-ID1 for a non-split pair; two cycles for the lower instruction of a split pair.

Reset
REQ-026 While reset is low: every output zero, state PAIR, buffer and buffered pc zero, fetch_hold 0.
REQ-027 Reset asserted mid-SPLIT discards the buffered instruction; first edge after release behaves as PAIR.

Configuration
REQ-028 Macro SPLIT_ISSUE_EN defined: dependency check, SPLIT state and buffer present as above.
REQ-029 SPLIT_ISSUE_EN undefined: no dependency logic or buffer; every non-stall, non-flush edge follows REQ-018; fetch_hold and split_active tied 0.

Structure
REQ-030 Shared package pipe_pkg holds PC width (8), instruction width (32), opcode constants of REQ-017 and the PAIR/SPLIT state encoding.
REQ-031 Sub-module pair_dep_check (combinational, inst1/inst2 in, dep out) is instantiated only under SPLIT_ISSUE_EN.

Verification
REQ-032 Independent pair: inst1=add $3,$1,$2 (0x00221820), inst2=add $6,$4,$5, pc_F=0x10 -> next edge valids 1/1, pc1_D=0x10, pcPlus2_D=0x12, fetch_hold 0.
REQ-033 Dependent pair: inst1=0x00221820, inst2=add $7,$3,$4, pc_F=0x20 -> fetch_hold 1; edge 1: valid2_D=0, pc1_D=0x20; edge 2: inst1_D=inst2, pc1_D=0x21, pcPlus2_D=0x22, split_active falls.
REQ-034 Dependent pair, stall held 3 cycles while in SPLIT -> outputs frozen, buffered instruction issued on the first edge after stall falls.
REQ-035 flush and stall both high while in SPLIT -> outputs zero, valids 0, state PAIR, buffer lost.
REQ-036 Wrap: pc_F=0xFF dependent pair -> pcPlus2_D=0x01, then split pc1_D=0x00; destination $0 in inst1 -> no split.
REQ-037 Reset low mid-SPLIT -> all outputs 0 immediately; after release, independent pair issues normally.
